bellek_hakem: RTL and testbench
===============================

BELLEK_HAKEM -- requirements
Module: bellek_hakem

Interface
REQ-001 The module SHALL have parameter ADRES_BIT, default 32, address width.
REQ-002 The module SHALL have parameter VERI_BIT, default 32, data width.
REQ-003 The module SHALL have parameter ONCELIK_VERI, default 0; 0 selects round-robin, 1 selects fixed priority to the data port.
REQ-004 The module SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The module SHALL have port g_istek  input  1  fetch-port read request.
REQ-007 The module SHALL have port g_adres  input  ADRES_BIT  fetch-port address.
REQ-008 The module SHALL have port g_hazir  output  1  fetch request accepted this cycle.
REQ-009 The module SHALL have port g_veri  output  VERI_BIT  fetch read data.
REQ-010 The module SHALL have port g_veri_gecerli  output  1  g_veri valid, one-cycle pulse.
REQ-011 The module SHALL have port v_istek  input  1  data-port request (load or store).
REQ-012 The module SHALL have port v_adres  input  ADRES_BIT  data-port address.
REQ-013 The module SHALL have port v_yaz  input  1  data-port request is a write.
REQ-014 The module SHALL have port v_yaz_veri  input  VERI_BIT  data-port write data.
REQ-015 The module SHALL have port v_hazir  output  1  data request accepted this cycle.
REQ-016 The module SHALL have port v_veri  output  VERI_BIT  data-port read data.
REQ-017 The module SHALL have port v_veri_gecerli  output  1  v_veri valid, one-cycle pulse.
REQ-018 The module SHALL have port bellek_adres  output  ADRES_BIT  memory address.
REQ-019 The module SHALL have port bellek_oku_veri  input  VERI_BIT  memory read data, valid one cycle after the address is presented.
REQ-020 The module SHALL have port bellek_yaz_veri  output  VERI_BIT  memory write data.
REQ-021 The module SHALL have port bellek_yaz  output  1  memory write strobe; the write commits on the rising edge where it is high.

Function
REQ-022 The FSM SHALL have two states: BOS (idle, may grant) and OKU (read outstanding, no grant).
REQ-023 In BOS with at least one istek high, exactly one hazir SHALL be asserted combinationally in the same cycle; no hazir SHALL be asserted in OKU.
REQ-024 Ties SHALL be resolved as follows: ONCELIK_VERI=1 grants the data port; ONCELIK_VERI=0 grants the port not recorded in son_kazanan, and a sole requester always wins.
REQ-025 son_kazanan SHALL update on every grant (read or write) and reset to "data", so the fetch port wins the first tie.
REQ-026 On the granted cycle, bellek_adres SHALL equal the winner's address; bellek_yaz SHALL equal v_yaz if the data port wins, else 0; bellek_yaz_veri SHALL equal v_yaz_veri.
REQ-027 A granted read SHALL move BOS->OKU; in OKU the winner's veri_gecerli SHALL be 1 and its veri SHALL equal bellek_oku_veri; OKU->BOS is unconditional next edge.
REQ-028 A granted write SHALL stay in BOS, complete in one cycle, and produce no veri_gecerli pulse.
REQ-029 Throughput SHALL be one read per 2 cycles and one write per cycle; back-to-back writes are allowed.
REQ-030 When no port is granted, bellek_adres, bellek_yaz_veri and bellek_yaz SHALL all be 0.
REQ-031 Requesters SHALL hold istek, address and data stable until hazir; dropping istek before hazir withdraws the request with no side effect.
REQ-032 A request raised during OKU SHALL wait, and SHALL be arbitrated in the following BOS cycle.
REQ-033 The winning port SHALL be registered at grant so the OKU data is steered to the correct port even if inputs change.

Reset
REQ-034 rst high SHALL force BOS and son_kazanan=data; all hazir, veri_gecerli and bellek_yaz outputs SHALL be 0 that cycle and after the edge.
REQ-035 rst asserted in OKU SHALL abort the read: no veri_gecerli pulse, next state BOS.
REQ-036 g_veri and v_veri SHALL be don't-care whenever their gecerli is 0.

Verification
REQ-037 Fetch read after reset: g_istek=1, g_adres=0x8000_0000 -> same cycle g_hazir=1, bellek_adres=0x8000_0000, bellek_yaz=0; next cycle g_veri_gecerli=1, g_veri equals the memory word.
REQ-038 Simultaneous reads, ONCELIK_VERI=0: both istek held -> fetch granted at cycle 0, data at cycle 2, fetch at cycle 4; strict alternation.
REQ-039 Write then read: v_yaz=1, v_adres=0x8000_0010, v_yaz_veri=0xDEADBEEF -> bellek_yaz=1 for one cycle, v_hazir=1, no gecerli; then a read of 0x8000_0010 -> v_veri=0xDEADBEEF with v_veri_gecerli=1.
REQ-040 ONCELIK_VERI=1 with both ports requesting continuously: data port wins every grant and g_hazir stays 0.
REQ-041 rst=1 during OKU: no gecerli pulse; next cycle all outputs are 0 and the state is BOS.
REQ-042 g_istek rises during OKU: g_hazir=0 in OKU and g_hazir=1 in the next BOS cycle.

Source files
------------

// File: rtl/bellek_hakem.sv
// Two-port memory arbiter: a fetch port (read-only) and a data port (read/write)
// share one synchronous-read memory; reads take two cycles, writes one.
module bellek_hakem #(
  parameter int ADRES_BIT    = 32,
  parameter int VERI_BIT     = 32,
  parameter int ONCELIK_VERI = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 g_istek,
  input  logic [ADRES_BIT-1:0] g_adres,
  output logic                 g_hazir,
  output logic [VERI_BIT-1:0]  g_veri,
  output logic                 g_veri_gecerli,
  input  logic                 v_istek,
  input  logic [ADRES_BIT-1:0] v_adres,
  input  logic                 v_yaz,
  input  logic [VERI_BIT-1:0]  v_yaz_veri,
  output logic                 v_hazir,
  output logic [VERI_BIT-1:0]  v_veri,
  output logic                 v_veri_gecerli,
  output logic [ADRES_BIT-1:0] bellek_adres,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz
);

  // state | meaning
  // BOS   | idle, may grant one port this cycle
  // OKU   | read outstanding, memory data returned to registered winner
  typedef enum logic {BOS, OKU} durum_t;

  localparam logic VERI_ONCELIKLI = (ONCELIK_VERI != 0);

  durum_t durum_q, durum_d;
  logic   son_kazanan_q, son_kazanan_d;   // 1 = data port won last grant
  logic   kazanan_q, kazanan_d;           // 1 = data port owns the read in OKU
  logic   g_sec, v_sec;

  // On a tie the data port wins under fixed priority, or when fetch won last.
  always_comb begin
    g_sec = g_istek && !(v_istek && (VERI_ONCELIKLI || !son_kazanan_q));
    v_sec = v_istek && !g_sec;
  end

  always_comb begin
    durum_d         = durum_q;
    son_kazanan_d   = son_kazanan_q;
    kazanan_d       = kazanan_q;
    g_hazir         = 1'b0;
    v_hazir         = 1'b0;
    g_veri_gecerli  = 1'b0;
    v_veri_gecerli  = 1'b0;
    g_veri          = bellek_oku_veri;
    v_veri          = bellek_oku_veri;
    bellek_adres    = '0;
    bellek_yaz_veri = '0;
    bellek_yaz      = 1'b0;
    case (durum_q)
      BOS: begin
        if (!rst && (g_sec || v_sec)) begin
          g_hazir         = g_sec;
          v_hazir         = v_sec;
          bellek_adres    = g_sec ? g_adres : v_adres;
          bellek_yaz_veri = v_yaz_veri;
          bellek_yaz      = v_sec && v_yaz;
          son_kazanan_d   = v_sec;
          kazanan_d       = v_sec;
          if (!(v_sec && v_yaz)) durum_d = OKU;
        end
      end
      OKU: begin
        durum_d = BOS;
        if (!rst) begin
          g_veri_gecerli = !kazanan_q;
          v_veri_gecerli = kazanan_q;
        end
      end
      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q       <= BOS;
      son_kazanan_q <= 1'b1;
      kazanan_q     <= 1'b0;
    end else begin
      durum_q       <= durum_d;
      son_kazanan_q <= son_kazanan_d;
      kazanan_q     <= kazanan_d;
    end
  end

endmodule

// File: tb/tb_bellek_hakem.sv
// Directed bench: round-robin instance with a small memory model, plus a
// fixed-priority instance sharing the same stimulus.
module tb_bellek_hakem;

  logic        clk = 1'b0;
  logic        rst;
  logic        g_istek, v_istek, v_yaz;
  logic [31:0] g_adres, v_adres, v_yaz_veri;

  logic        g_hazir, g_veri_gecerli, v_hazir, v_veri_gecerli, bellek_yaz;
  logic [31:0] g_veri, v_veri, bellek_adres, bellek_yaz_veri, bellek_oku_veri;

  logic        g_hazir1, g_veri_gecerli1, v_hazir1, v_veri_gecerli1, bellek_yaz1;
  logic [31:0] g_veri1, v_veri1, bellek_adres1, bellek_yaz_veri1, bellek_oku_veri1;

  int n_kontrol = 0;
  int n_gecen   = 0;

  always #5 clk = ~clk;

  bellek_hakem #(.ADRES_BIT(32), .VERI_BIT(32), .ONCELIK_VERI(0)) dut0 (
    .clk(clk), .rst(rst),
    .g_istek(g_istek), .g_adres(g_adres), .g_hazir(g_hazir),
    .g_veri(g_veri), .g_veri_gecerli(g_veri_gecerli),
    .v_istek(v_istek), .v_adres(v_adres), .v_yaz(v_yaz), .v_yaz_veri(v_yaz_veri),
    .v_hazir(v_hazir), .v_veri(v_veri), .v_veri_gecerli(v_veri_gecerli),
    .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri),
    .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz)
  );

  bellek_hakem #(.ADRES_BIT(32), .VERI_BIT(32), .ONCELIK_VERI(1)) dut1 (
    .clk(clk), .rst(rst),
    .g_istek(g_istek), .g_adres(g_adres), .g_hazir(g_hazir1),
    .g_veri(g_veri1), .g_veri_gecerli(g_veri_gecerli1),
    .v_istek(v_istek), .v_adres(v_adres), .v_yaz(v_yaz), .v_yaz_veri(v_yaz_veri),
    .v_hazir(v_hazir1), .v_veri(v_veri1), .v_veri_gecerli(v_veri_gecerli1),
    .bellek_adres(bellek_adres1), .bellek_oku_veri(bellek_oku_veri1),
    .bellek_yaz_veri(bellek_yaz_veri1), .bellek_yaz(bellek_yaz1)
  );

  // Unwritten words read back as 0xA50000_<word index>.
  logic [31:0] mem [0:255];
  bit   [255:0] yazildi;
  logic [7:0]  idx;
  assign idx = bellek_adres[9:2];

  always @(posedge clk) begin
    if (bellek_yaz) begin
      mem[idx]     <= bellek_yaz_veri;
      yazildi[idx] <= 1'b1;
    end
    bellek_oku_veri  <= yazildi[idx] ? mem[idx] : {24'hA50000, idx};
    bellek_oku_veri1 <= bellek_adres1 ^ 32'h5A5A5A5A;
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_kontrol++;
    if (gozlenen === beklenen) n_gecen++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic bosalt();
    g_istek = 0; v_istek = 0; v_yaz = 0;
    g_adres = '0; v_adres = '0; v_yaz_veri = '0;
  endtask

  initial begin
    bosalt();
    rst = 1; g_istek = 1;
    #1;
    kontrol("rst_g_hazir_comb", g_hazir, 0);
    adim();
    #1;
    kontrol("rst_g_hazir", g_hazir, 0);
    kontrol("rst_g_gecerli", g_veri_gecerli, 0);
    kontrol("rst_bellek_yaz", bellek_yaz, 0);

    // Fetch read right after reset
    adim();
    rst = 0; g_istek = 1; g_adres = 32'h8000_0000;
    #1;
    kontrol("t1_g_hazir", g_hazir, 1);
    kontrol("t1_v_hazir", v_hazir, 0);
    kontrol("t1_adres", bellek_adres, 32'h8000_0000);
    kontrol("t1_yaz", bellek_yaz, 0);
    adim();
    g_istek = 0;
    #1;
    kontrol("t1_g_gecerli", g_veri_gecerli, 1);
    kontrol("t1_g_veri", g_veri, 32'hA500_0000);
    kontrol("t1_oku_g_hazir", g_hazir, 0);
    kontrol("t1_oku_adres", bellek_adres, 0);

    // Simultaneous reads, round-robin from reset
    rst = 1;
    #1;
    adim();
    rst = 0;
    g_istek = 1; g_adres = 32'h8000_0004;
    v_istek = 1; v_adres = 32'h8000_0008;
    for (int c = 0; c < 6; c++) begin
      #1;
      kontrol($sformatf("t2_g_hazir_c%0d", c), g_hazir, (c % 4 == 0));
      kontrol($sformatf("t2_v_hazir_c%0d", c), v_hazir, (c % 4 == 2));
      kontrol($sformatf("t2_g_gec_c%0d", c), g_veri_gecerli, (c % 4 == 1));
      kontrol($sformatf("t2_v_gec_c%0d", c), v_veri_gecerli, (c % 4 == 3));
      if (c % 4 == 0) kontrol("t2_adres_g", bellek_adres, 32'h8000_0004);
      if (c % 4 == 2) kontrol("t2_adres_v", bellek_adres, 32'h8000_0008);
      if (c % 4 == 1) kontrol("t2_g_veri", g_veri, 32'hA500_0001);
      if (c % 4 == 3) kontrol("t2_v_veri", v_veri, 32'hA500_0002);
      adim();
    end
    bosalt();
    #1;
    kontrol("bos_adres", bellek_adres, 0);
    kontrol("bos_yaz_veri", bellek_yaz_veri, 0);
    kontrol("bos_yaz", bellek_yaz, 0);

    // Write then read back
    adim();
    v_istek = 1; v_yaz = 1; v_adres = 32'h8000_0010; v_yaz_veri = 32'hDEAD_BEEF;
    #1;
    kontrol("t3_v_hazir", v_hazir, 1);
    kontrol("t3_yaz", bellek_yaz, 1);
    kontrol("t3_adres", bellek_adres, 32'h8000_0010);
    kontrol("t3_yaz_veri", bellek_yaz_veri, 32'hDEAD_BEEF);
    adim();
    v_yaz = 0;
    #1;
    kontrol("t3_yazdan_sonra_gec", v_veri_gecerli, 0);
    kontrol("t3_oku_v_hazir", v_hazir, 1);
    kontrol("t3_oku_yaz", bellek_yaz, 0);
    adim();
    v_istek = 0;
    #1;
    kontrol("t3_v_gecerli", v_veri_gecerli, 1);
    kontrol("t3_v_veri", v_veri, 32'hDEAD_BEEF);
    kontrol("t3_g_gecerli", g_veri_gecerli, 0);

    // Back-to-back writes, then read the first one
    adim();
    v_istek = 1; v_yaz = 1; v_adres = 32'h8000_0014; v_yaz_veri = 32'h1234_5678;
    #1;
    kontrol("t3b_w1_hazir", v_hazir, 1);
    adim();
    v_adres = 32'h8000_0018; v_yaz_veri = 32'hCAFE_F00D;
    #1;
    kontrol("t3b_w2_hazir", v_hazir, 1);
    kontrol("t3b_w2_yaz", bellek_yaz, 1);
    kontrol("t3b_w2_veri", bellek_yaz_veri, 32'hCAFE_F00D);
    adim();
    v_yaz = 0; v_adres = 32'h8000_0014;
    #1;
    kontrol("t3b_r_hazir", v_hazir, 1);
    adim();
    v_istek = 0;
    #1;
    kontrol("t3b_r_veri", v_veri, 32'h1234_5678);

    // Fetch request raised during a data-port read
    adim();
    v_istek = 1; v_adres = 32'h8000_001C;
    #1;
    kontrol("t4_v_hazir", v_hazir, 1);
    adim();
    v_istek = 0; g_istek = 1; g_adres = 32'h8000_0020;
    #1;
    kontrol("t4_oku_g_hazir", g_hazir, 0);
    kontrol("t4_v_gecerli", v_veri_gecerli, 1);
    kontrol("t4_g_gecerli", g_veri_gecerli, 0);
    kontrol("t4_v_veri", v_veri, 32'hA500_0007);
    adim();
    #1;
    kontrol("t4_bos_g_hazir", g_hazir, 1);
    kontrol("t4_bos_adres", bellek_adres, 32'h8000_0020);
    adim();
    g_istek = 0;
    #1;
    kontrol("t4_g_veri", g_veri, 32'hA500_0008);

    // Reset during a read aborts it
    adim();
    g_istek = 1; g_adres = 32'h8000_0000;
    #1;
    kontrol("t5_g_hazir", g_hazir, 1);
    adim();
    g_istek = 0; rst = 1;
    #1;
    kontrol("t5_rst_g_gec", g_veri_gecerli, 0);
    kontrol("t5_rst_v_gec", v_veri_gecerli, 0);
    adim();
    rst = 0;
    #1;
    kontrol("t5_g_gec", g_veri_gecerli, 0);
    kontrol("t5_adres", bellek_adres, 0);
    kontrol("t5_yaz", bellek_yaz, 0);
    kontrol("t5_v_hazir", v_hazir, 0);
    g_istek = 1;
    #1;
    kontrol("t5_bos_g_hazir", g_hazir, 1);

    // Fixed priority instance: data port wins every grant
    rst = 1;
    #1;
    adim();
    rst = 0;
    g_istek = 1; g_adres = 32'h8000_0004;
    v_istek = 1; v_adres = 32'h8000_0030;
    for (int c = 0; c < 6; c++) begin
      #1;
      kontrol($sformatf("t6_g_hazir_c%0d", c), g_hazir1, 0);
      kontrol($sformatf("t6_v_hazir_c%0d", c), v_hazir1, (c % 2 == 0));
      kontrol($sformatf("t6_v_gec_c%0d", c), v_veri_gecerli1, (c % 2 == 1));
      if (c % 2 == 1) kontrol("t6_v_veri", v_veri1, 32'hDA5A_5A6A);
      adim();
    end
    bosalt();

    $display("%0d/%0d checks passed", n_gecen, n_kontrol);
    $finish;
  end

endmodule
